// File: rtl/alu_md_if.sv
// Handshake bundle for the alu_md request/response path.
// Master issues operations and consumes results; slave is the ALU.
interface alu_md_if #(
    parameter int REG_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           alu_control;
    logic [REG_WIDTH-1:0] in1;
    logic [REG_WIDTH-1:0] in2;
    logic                 out_valid;
    logic                 out_ready;
    logic [REG_WIDTH-1:0] result;
    logic                 zero;
    logic                 sign;
    logic                 busy;

    modport master (
        output in_valid, alu_control, in1, in2, out_ready,
        input  in_ready, out_valid, result, zero, sign, busy
    );

    modport slave (
        input  in_valid, alu_control, in1, in2, out_ready,
        output in_ready, out_valid, result, zero, sign, busy
    );
endinterface

// File: rtl/alu_md.sv
// ALU with optional iterative multiply/divide (one bit per cycle).
// Define ALU_MULDIV_EN to build the multiply/divide datapath.
module alu_md #(
    parameter int REG_WIDTH = 32
) (
    input logic     clk,
    input logic     reset,
    alu_md_if.slave bus
);
    localparam int W  = REG_WIDTH;
    localparam int SW = $clog2(REG_WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic          is_md;
    logic          md_last;
    logic          load_res;
    logic [SW-1:0] shamt;
    logic [W-1:0]  alu_res;
    logic [W-1:0]  md_res;
    logic [W-1:0]  res_nxt;
    logic [W-1:0]  result_q;
    logic          zero_q;
    logic          sign_q;

    assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.sign      = sign_q;

    assign shamt = bus.in2[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (bus.alu_control)
            4'b0000: alu_res = bus.in1 & bus.in2;
            4'b0001: alu_res = bus.in1 | bus.in2;
            4'b0010: alu_res = bus.in1 + bus.in2;
            4'b0011: alu_res = bus.in1 ^ bus.in2;
            4'b0110: alu_res = bus.in1 - bus.in2;
            4'b0111: alu_res = bus.in1 << shamt;
            4'b1000: alu_res = bus.in1 >> shamt;
            4'b1001: alu_res = $signed(bus.in1) >>> shamt;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [W-1:0]  opb;
    logic [W-1:0]  hi_nxt;
    logic [W-1:0]  lo_nxt;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [2:0]    md_op;
    logic [SW-1:0] cnt;
    logic          neg_q;
    logic          neg_r;
    logic          a_neg;
    logic          b_neg;
    logic          qbit;
    logic [W:0]    sum;
    logic [W:0]    shl;
    logic [W:0]    diff;

    // 1010..1111; bit2 selects divide, bit0 clear means signed divide
    assign is_md = bus.alu_control[3]
                 & (bus.alu_control[2] | bus.alu_control[1]);
    assign a_neg = bus.alu_control[2] & ~bus.alu_control[0] & bus.in1[W-1];
    assign b_neg = bus.alu_control[2] & ~bus.alu_control[0] & bus.in2[W-1];
    assign a_mag = a_neg ? (~bus.in1 + 1'b1) : bus.in1;
    assign b_mag = b_neg ? (~bus.in2 + 1'b1) : bus.in2;

    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        shl    = {hi, lo[W-1]};
        diff   = shl - {1'b0, opb};
        qbit   = ~diff[W];
        hi_nxt = sum[W:1];
        lo_nxt = {sum[0], lo[W-1:1]};
        if (md_op[2]) begin
            hi_nxt = qbit ? diff[W-1:0] : shl[W-1:0];
            lo_nxt = {lo[W-2:0], qbit};
        end
    end

    assign md_last = (state == BUSY) && (cnt == SW'(W - 1));

    // Final value comes straight from the last iteration's next-state
    always_comb begin
        md_res = md_op[0] ? hi_nxt : lo_nxt;
        if (md_op[2]) begin
            if (md_op[1])
                md_res = neg_r ? (~hi_nxt + 1'b1) : hi_nxt;
            else
                md_res = neg_q ? (~lo_nxt + 1'b1) : lo_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi    <= '0;
            lo    <= '0;
            opb   <= '0;
            md_op <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept && is_md) begin
            md_op <= bus.alu_control[2:0];
            cnt   <= '0;
            hi    <= '0;
            if (bus.alu_control[2]) begin
                lo    <= a_mag;
                opb   <= b_mag;
                // a zero divisor keeps the all-ones quotient unsigned
                neg_q <= (a_neg ^ b_neg) && (bus.in2 != '0);
                neg_r <= a_neg;
            end else begin
                lo    <= bus.in2;
                opb   <= bus.in1;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end
        end else if (state == BUSY) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + 1'b1;
        end
    end

    assign bus.busy = (state == BUSY);
`else
    assign is_md    = 1'b0;
    assign md_last  = 1'b0;
    assign md_res   = '0;
    assign bus.busy = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = is_md ? BUSY : DONE;
            BUSY: if (md_last) state_nxt = DONE;
            DONE: begin
                if (accept)
                    state_nxt = is_md ? BUSY : DONE;
                else if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign load_res = (accept && !is_md) || md_last;
    assign res_nxt  = md_last ? md_res : alu_res;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            sign_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_res) begin
                result_q <= res_nxt;
                zero_q   <= (res_nxt == '0);
                sign_q   <= res_nxt[W-1];
            end
        end
    end
endmodule

// File: tb/tb_alu_md.sv
// Directed testbench for alu_md (REG_WIDTH=32).
// Multiply/divide vectors apply only when ALU_MULDIV_EN is defined.
module tb_alu_md;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    alu_md_if #(.REG_WIDTH(32)) bus ();

    alu_md #(.REG_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        bus.in_valid    = 1'b1;
        bus.alu_control = op;
        bus.in1         = a;
        bus.in2         = b;
    endtask

    task automatic single(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        drive(op, a, b);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check({tag, " ov"}, bus.out_valid, 1);
        check(tag, bus.result, exp);
        check({tag, " z"}, bus.zero, exp == 0);
        check({tag, " s"}, bus.sign, exp[31]);
    endtask

    task automatic md(input string tag, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp);
        int n;
        drive(op, a, b);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check({tag, " busy"}, bus.busy, 1);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " lat"}, n, 32);
        check(tag, bus.result, exp);
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.alu_control = 4'b0;
        bus.in1         = '0;
        bus.in2         = '0;
        bus.out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", bus.in_ready, 1);
        check("rst out_valid", bus.out_valid, 0);
        check("rst busy", bus.busy, 0);
        check("rst result", bus.result, 0);
        check("rst zero", bus.zero, 1);
        check("rst sign", bus.sign, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        single("sra", 4'b1001, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
        single("add wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0);
        single("and", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        single("or", 4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
        single("sub", 4'b0110, 32'h5, 32'h7, 32'hFFFF_FFFE);
        single("sll", 4'b0111, 32'h1, 32'h3F, 32'h8000_0000);
        single("srl", 4'b1000, 32'h8000_0000, 32'h3F, 32'h1);
`ifndef ALU_MULDIV_EN
        single("div off", 4'b1100, 32'd100, 32'd7, 32'h0);
        check("div off busy", bus.busy, 0);
        single("mulhu off", 4'b1011, 32'h0001_0000, 32'h0001_0000, 32'h0);
`endif
        single("xor", 4'b0011, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A);
        single("undef", 4'b0100, 32'h1234_5678, 32'h1, 32'h0);

`ifdef ALU_MULDIV_EN
        md("mul", 4'b1010, 32'h0001_0000, 32'h0001_0000, 32'h0);
        check("mul zero", bus.zero, 1);
        md("mulhu", 4'b1011, 32'h0001_0000, 32'h0001_0000, 32'h1);
        md("div ovf", 4'b1100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        md("rem ovf", 4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        md("divu by0", 4'b1101, 32'd7, 32'd0, 32'hFFFF_FFFF);
        md("remu by0", 4'b1111, 32'd7, 32'd0, 32'd7);
        md("div neg", 4'b1100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        md("rem neg", 4'b1110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
`endif

        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        single("hold add", 4'b0010, 32'd3, 32'd4, 32'd7);
        for (int i = 0; i < 3; i++) begin
            drive(4'b0010, 32'd100, i);
            bus.in_valid = (i != 1);
            check("hold in_ready", bus.in_ready, 0);
            @(posedge clk); #1;
            check("hold result", bus.result, 32'd7);
            check("hold out_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(4'b0010, i * 16, i);
            @(posedge clk); #1;
            check("stream result", bus.result, i * 17);
            check("stream out_valid", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("stream drain", bus.out_valid, 0);

        bus.out_ready = 1'b0;
        single("pre rst", 4'b0010, 32'd5, 32'd6, 32'd11);
        #2;
        reset = 1'b1;
        #1;
        check("arst out_valid", bus.out_valid, 0);
        check("arst in_ready", bus.in_ready, 1);
        check("arst result", bus.result, 0);
        check("arst zero", bus.zero, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        single("post rst", 4'b0010, 32'd2, 32'd3, 32'd5);

`ifdef ALU_MULDIV_EN
        drive(4'b1100, 32'd1000, 32'd3);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("brst busy", bus.busy, 0);
        check("brst out_valid", bus.out_valid, 0);
        check("brst in_ready", bus.in_ready, 1);
        check("brst result", bus.result, 0);
        check("brst zero", bus.zero, 1);
        check("brst sign", bus.sign, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        md("divu", 4'b1101, 32'd100, 32'd7, 32'd14);
        md("remu", 4'b1111, 32'd100, 32'd7, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter REG_WIDTH, default 32, operand/result width; SHALL be a power of two, 8 to 64.
REQ-002 Port clk  input  1  single clock; all state on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port in_valid  input  1  operation request valid.
REQ-005 Port in_ready  output  1  block can accept an operation this cycle.
REQ-006 Port alu_control  input  4  opcode, sampled on accept.
REQ-007 Port in1  input  REG_WIDTH  operand 1, sampled on accept.
REQ-008 Port in2  input  REG_WIDTH  operand 2, sampled on accept.
REQ-009 Port out_valid  output  1  result/zero/sign valid.
REQ-010 Port out_ready  input  1  consumer accepts result.
REQ-011 Port result  output  REG_WIDTH  registered operation result.
REQ-012 Port zero  output  1  registered, high when result is all zeros.
REQ-013 Port sign  output  1  registered, equals result[REG_WIDTH-1].
REQ-014 Port busy  output  1  high while in BUSY state.

Function
REQ-015 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL (low half), 1011 MULHU (high half, unsigned), 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
REQ-016 Shift amount SHALL be in2[log2(REG_WIDTH)-1:0]; SRA SHALL replicate in1 MSB.
REQ-017 Undefined opcodes (0100, 0101) SHALL produce result 0, zero 1, sign 0, latency 1.
REQ-018 Add/sub SHALL wrap modulo 2^REG_WIDTH; no carry/overflow output.
REQ-019 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-020 Accept SHALL occur when in_valid and in_ready both high; in_ready = (IDLE) or (DONE and out_ready).
REQ-021 Single-cycle ops (REQ-015 codes 0000-1001, undefined): accept -> DONE next edge with result loaded; latency 1.
REQ-022 Mul/div ops: accept -> BUSY; iterative shift-add/restoring-divide, one bit per cycle, REG_WIDTH cycles; then DONE; latency REG_WIDTH+1.
REQ-023 Signed DIV/REM SHALL divide magnitudes then fix signs; quotient truncates toward zero, remainder takes dividend sign.
REQ-024 Divide by zero: DIV/DIVU result all ones; REM/REMU result = in1.
REQ-025 Signed overflow (most-negative / -1): DIV result most-negative, REM result 0.
REQ-026 DONE holds result, zero, sign, out_valid stable until out_ready; out_valid=1 only in DONE.
REQ-027 DONE with out_ready and no accept -> IDLE; DONE with out_ready and accept -> next op starts same edge (back-to-back single-cycle throughput 1/cycle).
REQ-028 in_valid during BUSY SHALL be ignored (in_ready=0); operands and opcode latched only on accept.

Reset
REQ-029 reset SHALL force IDLE immediately, regardless of clk or state, including mid-BUSY; in-flight op discarded.
REQ-030 Reset values: in_ready 1, out_valid 0, busy 0, result 0, zero 1, sign 0; all internal iteration registers 0.

Configuration
REQ-031 Macro ALU_MULDIV_EN: defined -> opcodes 1010-1111 per REQ-022..025; undefined -> no multiply/divide datapath synthesised, BUSY state unreachable, busy tied 0, opcodes 1010-1111 treated as undefined per REQ-017.

Verification
REQ-032 REG_WIDTH=32, ADD in1=0xFFFFFFFF in2=1, out_ready=1 -> out_valid 1 cycle after accept, result 0, zero 1, sign 0.
REQ-033 SRA in1=0x80000000 in2=0x00000024 -> shift 4, result 0xF8000000, sign 1.
REQ-034 MUL in1=0x00010000 in2=0x00010000 (ALU_MULDIV_EN) -> busy 32 cycles, result 0, zero 1; MULHU same operands -> result 0x00000001.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
REQ-036 Hold out_ready=0 3 cycles after result, toggle in_valid -> result stable, no accept; then back-to-back ADD stream with out_ready=1 -> one result per cycle.
REQ-037 Assert reset at cycle 10 of DIV -> outputs at reset values same cycle; next op after release completes correctly; without ALU_MULDIV_EN, DIV -> result 0 after 1 cycle.
